// File: rtl/mt32_i2s_rx.sv
`default_nettype none
// ============================================================================
// Module   : mt32_i2s_rx
// Brief    : I2S receiver for an MT32-pi on the user port, with cable-orientation
//            detection, bclk debounce, and MIDI-out recovery.
// Revision : 1.0
// ============================================================================
module mt32_i2s_rx #(
  parameter int WIDTH     = 16,
  parameter int RATE_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       usr_in,
  output logic [WIDTH-1:0] sample_l,
  output logic [WIDTH-1:0] sample_r,
  output logic             sample_stb,
  output logic             midi_rx,
  output logic             crossed,
  output logic             locked
);

  localparam int                   CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(WIDTH);
  localparam logic [RATE_BITS-1:0] RATE_MAX = '1;
  localparam logic [WIDTH-1:0]     TOP_BIT  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [4:0]                sync1, sync2;
  logic [1:0]                pin_s2, pin_s2_d, filt, filt_d, rise;
  logic [1:0][RATE_BITS-1:0] cnt, period;
  logic [WIDTH-1:0]          word_buf;
  logic [CNT_W-1:0]          bit_cnt;
  logic                      ws_q, commit;
  logic                      cross_next, ws_sel, data_sel, midi_sel, bclk_rise, ws_reload;

  // Index 0 tracks pin4, index 1 tracks pin6.
  assign pin_s2     = {sync2[4], sync2[2]};
  assign rise       = filt & ~filt_d;
  assign cross_next = (period[0] <= period[1]);

  always_comb begin
    ws_sel    = crossed ? sync2[0] : sync2[3];
    data_sel  = crossed ? sync2[3] : sync2[0];
    midi_sel  = crossed ? sync2[4] : sync2[2];
    bclk_rise = crossed ? rise[0]  : rise[1];
    ws_reload = cross_next ? sync2[0] : sync2[3];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= '0;
      sync2      <= '0;
      pin_s2_d   <= '0;
      filt       <= '0;
      filt_d     <= '0;
      cnt        <= '0;
      period     <= {2{RATE_MAX}};
      word_buf   <= '0;
      bit_cnt    <= '0;
      ws_q       <= 1'b0;
      commit     <= 1'b0;
      sample_l   <= '0;
      sample_r   <= '0;
      sample_stb <= 1'b0;
      midi_rx    <= 1'b1;
      crossed    <= 1'b0;
      locked     <= 1'b0;
    end else begin
      sync1    <= usr_in;
      sync2    <= sync1;
      pin_s2_d <= pin_s2;
      filt_d   <= filt;

      // Filtered level follows only a value held for two consecutive cycles,
      // and the period meters count between filtered rising edges.
      for (int i = 0; i < 2; i++) begin
        if (pin_s2[i] == pin_s2_d[i]) filt[i] <= pin_s2[i];
        if (rise[i]) begin
          period[i] <= cnt[i];
          cnt[i]    <= '0;
        end else if (cnt[i] == RATE_MAX) begin
          period[i] <= RATE_MAX;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end

      midi_rx    <= midi_sel;
      locked     <= ((crossed ? period[0] : period[1]) != RATE_MAX);
      sample_stb <= 1'b0;
      commit     <= 1'b0;

      if (cross_next != crossed) begin
        // Re-routing invalidates any word in progress.
        crossed  <= cross_next;
        word_buf <= '0;
        bit_cnt  <= '0;
        ws_q     <= ws_reload;
      end else if (commit) begin
        if (locked) begin
          if (ws_q) begin
            sample_l <= word_buf;
          end else begin
            sample_r   <= word_buf;
            sample_stb <= 1'b1;
          end
        end
        word_buf <= '0;
        bit_cnt  <= '0;
      end else if (bclk_rise) begin
        if (bit_cnt < CNT_FULL) begin
          if (data_sel) word_buf <= word_buf | (TOP_BIT >> bit_cnt);
          bit_cnt <= bit_cnt + 1'b1;
        end
        ws_q   <= ws_sel;
        commit <= (ws_sel != ws_q);
      end
    end
  end

endmodule
`default_nettype wire
